pmem_loader: RTL and testbench

- Byte-stream writer that fills the program memory BRAM, which the CPU only ever reads.
- Receives a framed image over a valid/ready byte interface, assembles little-endian 32-bit words and drives the BRAM write port (wr_addr, ram_in, byte_w_en).
- Holds the CPU in reset (cpu_rst) until a complete, checksum-verified image has been written.
- Sits between a host-side byte source (UART RX, JTAG bridge, testbench) and program_memory_cpu's write port.

---
 rtl/pmem_loader_pkg.sv | 16 +
 rtl/loader_word_assembler.sv | 58 +++++
 rtl/pmem_loader.sv | 145 ++++++++++++++
 tb/tb_pmem_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pmem_loader_pkg.sv
// Shared constants and state encoding for the program-memory image loader.
package pmem_loader_pkg;

   typedef enum logic [2:0] {
      LOADER_LEN_LO = 3'd0,
      LOADER_LEN_HI = 3'd1,
      LOADER_DATA   = 3'd2,
      LOADER_CSUM   = 3'd3,
      LOADER_DONE   = 3'd4,
      LOADER_ERROR  = 3'd5
   } loader_state_e;

   localparam int         BYTES_PER_WORD = 4;
   localparam logic [3:0] BYTE_W_EN_ALL  = 4'hF;

endpackage

// File: rtl/loader_word_assembler.sv
// Packs little-endian bytes into 32-bit words; registered one-cycle word strobe.
module loader_word_assembler
   import pmem_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  sysclk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  byte_vld,
   input  logic [7:0]            byte_dat,
   output logic                  word_cmpl,
   output logic                  word_vld,
   output logic [DATA_WIDTH-1:0] word_dat
);

   logic [1:0]            idx_q, idx_d;
   logic [DATA_WIDTH-1:0] asm_q, asm_d;
   logic                  word_vld_q, word_vld_d;
   logic [DATA_WIDTH-1:0] word_dat_q, word_dat_d;

   always_comb begin
      idx_d      = idx_q;
      asm_d      = asm_q;
      word_vld_d = 1'b0;
      word_dat_d = word_dat_q;
      word_cmpl  = byte_vld && !clear && (idx_q == 2'(BYTES_PER_WORD - 1));
      if (clear) begin
         idx_d = 2'd0;
      end else if (byte_vld) begin
         asm_d[{idx_q, 3'b000} +: 8] = byte_dat;
         idx_d = idx_q + 2'd1;
         // Final byte bypasses asm_q so the full word is captured this cycle.
         if (word_cmpl) begin
            word_vld_d = 1'b1;
            word_dat_d = {byte_dat, asm_q[DATA_WIDTH-9:0]};
         end
      end
   end

   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         idx_q      <= 2'd0;
         asm_q      <= '0;
         word_vld_q <= 1'b0;
         word_dat_q <= '0;
      end else begin
         idx_q      <= idx_d;
         asm_q      <= asm_d;
         word_vld_q <= word_vld_d;
         word_dat_q <= word_dat_d;
      end
   end

   assign word_vld = word_vld_q;
   assign word_dat = word_dat_q;

endmodule

// File: rtl/pmem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte frame into program memory and
// holds the CPU in reset until a verified image is in place.
module pmem_loader
   import pmem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  sysclk,
   input  logic                  rst,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  restart,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] ram_in,
   output logic [3:0]            byte_w_en,
   output logic                  cpu_rst,
   output logic                  loading,
   output logic                  done,
   output logic                  error,
   output logic [LEN_WIDTH-1:0]  words_written
);

   localparam logic [LEN_WIDTH:0] DEPTH_W = (LEN_WIDTH + 1)'(2 ** ADDR_WIDTH);

   loader_state_e         state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  words_q, words_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]            csum_q, csum_d;
   logic                  started_q, started_d;

   logic                  accept;
   logic                  asm_byte_vld;
   logic                  asm_clear;
   logic                  word_cmpl;
   logic                  word_vld;
   logic [LEN_WIDTH-1:0]  len_full;

   assign in_ready     = (state_q == LOADER_LEN_LO) || (state_q == LOADER_LEN_HI) ||
                         (state_q == LOADER_DATA)   || (state_q == LOADER_CSUM);
   assign accept       = in_valid && in_ready;
   assign asm_byte_vld = accept && !restart && (state_q == LOADER_DATA);
   assign asm_clear    = restart || (state_q != LOADER_DATA);
   assign len_full     = LEN_WIDTH'({in_data, len_q[7:0]});

   loader_word_assembler #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_asm (
      .sysclk    (sysclk),
      .rst       (rst),
      .clear     (asm_clear),
      .byte_vld  (asm_byte_vld),
      .byte_dat  (in_data),
      .word_cmpl (word_cmpl),
      .word_vld  (word_vld),
      .word_dat  (ram_in)
   );

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      words_d   = words_q;
      waddr_d   = waddr_q;
      wr_addr_d = wr_addr_q;
      csum_d    = csum_q;
      started_d = started_q;
      // Restart outranks a same-cycle byte, which is simply dropped.
      if (restart) begin
         state_d = LOADER_LEN_LO;
         csum_d  = 8'h00;
         words_d = '0;
         waddr_d = '0;
      end else begin
         case (state_q)
            LOADER_LEN_LO: if (accept) begin
               len_d[7:0] = in_data;
               csum_d     = csum_q ^ in_data;
               started_d  = 1'b1;
               state_d    = LOADER_LEN_HI;
            end
            LOADER_LEN_HI: if (accept) begin
               len_d  = len_full;
               csum_d = csum_q ^ in_data;
               if ({1'b0, len_full} > DEPTH_W) begin
                  state_d = LOADER_ERROR;
               end else if (len_full == '0) begin
                  state_d = LOADER_CSUM;
               end else begin
                  state_d = LOADER_DATA;
                  waddr_d = '0;
                  words_d = '0;
               end
            end
            LOADER_DATA: if (accept) begin
               csum_d = csum_q ^ in_data;
               if (word_cmpl) begin
                  wr_addr_d = waddr_q;
                  waddr_d   = waddr_q + 1'b1;
                  words_d   = words_q + 1'b1;
                  if (words_q + 1'b1 == len_q) begin
                     state_d = LOADER_CSUM;
                  end
               end
            end
            LOADER_CSUM: if (accept) begin
               state_d = (in_data == csum_q) ? LOADER_DONE : LOADER_ERROR;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         state_q   <= LOADER_LEN_LO;
         len_q     <= '0;
         words_q   <= '0;
         waddr_q   <= '0;
         wr_addr_q <= '0;
         csum_q    <= 8'h00;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         words_q   <= words_d;
         waddr_q   <= waddr_d;
         wr_addr_q <= wr_addr_d;
         csum_q    <= csum_d;
         started_q <= started_d;
      end
   end

   assign wr_addr       = wr_addr_q;
   assign byte_w_en     = word_vld ? BYTE_W_EN_ALL : 4'h0;
   assign done          = (state_q == LOADER_DONE);
   assign error         = (state_q == LOADER_ERROR);
   assign cpu_rst       = (state_q != LOADER_DONE);
   assign loading       = started_q && in_ready;
   assign words_written = words_q;

endmodule

// File: tb/tb_pmem_loader.sv
// Directed bench for pmem_loader: frames driven at negedge, outputs sampled at negedge.
module tb_pmem_loader;

   logic        sysclk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        restart;
   logic [11:0] wr_addr;
   logic [31:0] ram_in;
   logic [3:0]  byte_w_en;
   logic        cpu_rst;
   logic        loading;
   logic        done;
   logic        error;
   logic [15:0] words_written;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] img [0:15];
   logic [11:0] st_addr [$];
   logic [31:0] st_data [$];

   always #5 sysclk = ~sysclk;

   pmem_loader #(
      .ADDR_WIDTH (12),
      .DATA_WIDTH (32),
      .LEN_WIDTH  (16)
   ) dut (
      .sysclk        (sysclk),
      .rst           (rst),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .restart       (restart),
      .wr_addr       (wr_addr),
      .ram_in        (ram_in),
      .byte_w_en     (byte_w_en),
      .cpu_rst       (cpu_rst),
      .loading       (loading),
      .done          (done),
      .error         (error),
      .words_written (words_written)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   always @(negedge sysclk) begin
      if (byte_w_en !== 4'h0) begin
         chk("bwe_all", {28'h0, byte_w_en}, 32'hF);
         st_addr.push_back(wr_addr);
         st_data.push_back(ram_in);
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      in_data  = b;
      in_valid = 1'b1;
      @(negedge sysclk);
      in_valid = 1'b0;
      repeat (gap) @(negedge sysclk);
   endtask

   // Sends N words from img; csum_flip corrupts the checksum, first gap_words words are gapped.
   task automatic send_frame(input int n, input logic [7:0] csum_flip, input int gap_words);
      logic [7:0] cs;
      logic [7:0] b;
      int         g;
      cs = 8'h00;
      b = n[7:0];  cs ^= b; send_byte(b, 0);
      b = n[15:8]; cs ^= b; send_byte(b, 0);
      for (int w = 0; w < n; w++) begin
         for (int k = 0; k < 4; k++) begin
            b  = img[w][8*k +: 8];
            cs ^= b;
            g  = (w < gap_words) ? int'($urandom_range(1, 5)) : 0;
            send_byte(b, g);
         end
      end
      send_byte(cs ^ csum_flip, 0);
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(negedge sysclk);
      restart = 1'b0;
   endtask

   task automatic check_strobes(input string tag, input int n);
      chk({tag, "_nstrobes"}, st_addr.size(), n);
      for (int i = 0; i < n && i < st_addr.size(); i++) begin
         chk({tag, "_addr"}, {20'h0, st_addr[i]}, i);
         chk({tag, "_data"}, st_data[i], img[i]);
      end
      st_addr.delete();
      st_data.delete();
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      restart  = 1'b0;
      #3;
      chk("rst_cpu_rst",  {31'h0, cpu_rst},  1);
      chk("rst_in_ready", {31'h0, in_ready}, 1);
      chk("rst_bwe",      {28'h0, byte_w_en}, 0);
      chk("rst_wr_addr",  {20'h0, wr_addr},  0);
      chk("rst_ram_in",   ram_in,            0);
      chk("rst_done",     {31'h0, done},     0);
      chk("rst_error",    {31'h0, error},    0);
      chk("rst_loading",  {31'h0, loading},  0);
      chk("rst_words",    {16'h0, words_written}, 0);
      @(negedge sysclk);
      @(negedge sysclk);
      rst = 1'b1;
      @(negedge sysclk);

      // 1: two-word image, checksum 0x7E
      img[0] = 32'h0000_0013;
      img[1] = 32'h0000_006F;
      send_frame(2, 8'h00, 0);
      check_strobes("t1", 2);
      chk("t1_done",     {31'h0, done},     1);
      chk("t1_cpu_rst",  {31'h0, cpu_rst},  0);
      chk("t1_words",    {16'h0, words_written}, 2);
      chk("t1_in_ready", {31'h0, in_ready}, 0);
      chk("t1_error",    {31'h0, error},    0);
      pulse_restart();
      chk("t1r_done",    {31'h0, done},     0);
      chk("t1r_cpu_rst", {31'h0, cpu_rst},  1);
      chk("t1r_words",   {16'h0, words_written}, 0);

      // 2: same image, checksum 0x7F
      send_frame(2, 8'h01, 0);
      check_strobes("t2", 2);
      chk("t2_error",   {31'h0, error},   1);
      chk("t2_done",    {31'h0, done},    0);
      chk("t2_cpu_rst", {31'h0, cpu_rst}, 1);
      chk("t2_in_ready", {31'h0, in_ready}, 0);
      repeat (3) @(negedge sysclk);
      chk("t2_error_sticky", {31'h0, error}, 1);
      pulse_restart();
      chk("t2r_error",    {31'h0, error},    0);
      chk("t2r_in_ready", {31'h0, in_ready}, 1);
      chk("t2r_cpu_rst",  {31'h0, cpu_rst},  1);

      // 3: length 0x1001 exceeds 4096 words
      send_byte(8'h01, 0);
      send_byte(8'h10, 0);
      chk("t3_error", {31'h0, error}, 1);
      repeat (4) @(negedge sysclk);
      check_strobes("t3", 0);
      pulse_restart();

      // 4: empty image
      send_frame(0, 8'h00, 0);
      chk("t4_done",  {31'h0, done}, 1);
      chk("t4_words", {16'h0, words_written}, 0);
      check_strobes("t4", 0);
      pulse_restart();

      // 5: 16 words, first half gapped, second half back-to-back
      for (int i = 0; i < 16; i++) img[i] = 32'h1F00_A500 + 32'h0103_0207 * i;
      send_frame(16, 8'h00, 8);
      check_strobes("t5", 16);
      chk("t5_done",  {31'h0, done}, 1);
      chk("t5_words", {16'h0, words_written}, 16);
      pulse_restart();

      // 6a: async reset after byte 2 of word 3 of a 5-word frame
      send_byte(8'h05, 0);
      send_byte(8'h00, 0);
      for (int w = 0; w < 3; w++)
         for (int k = 0; k < 4; k++) send_byte(img[w][8*k +: 8], 0);
      send_byte(img[3][7:0], 0);
      send_byte(img[3][15:8], 0);
      #1 rst = 1'b0;
      #1;
      chk("t6_bwe",      {28'h0, byte_w_en}, 0);
      chk("t6_in_ready", {31'h0, in_ready}, 1);
      chk("t6_loading",  {31'h0, loading},  0);
      chk("t6_cpu_rst",  {31'h0, cpu_rst},  1);
      chk("t6_words",    {16'h0, words_written}, 0);
      @(negedge sysclk);
      rst = 1'b1;
      @(negedge sysclk);

      // 6b: async reset while a write strobe is pending
      send_byte(8'h05, 0);
      send_byte(8'h00, 0);
      for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 0);
      chk("t6b_strobe_pending", {28'h0, byte_w_en}, 32'hF);
      #1 rst = 1'b0;
      #1;
      chk("t6b_bwe", {28'h0, byte_w_en}, 0);
      @(negedge sysclk);
      rst = 1'b1;
      @(negedge sysclk);
      st_addr.delete();
      st_data.delete();

      send_frame(5, 8'h00, 0);
      check_strobes("t6", 5);
      chk("t6_done",     {31'h0, done},    1);
      chk("t6_cpu_rst2", {31'h0, cpu_rst}, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
